// File: rtl/branch_pkg.sv
// branch_pkg: shared encodings for the execute-stage branch controller
package branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {K_BR, K_JAL, K_JALR, K_RSV} br_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REDIRECT, S_FLUSH} state_e;
endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: decode op handshake, resolution, redirect and statistics signals
interface branch_ctrl_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
  logic             br_valid_i;
  logic             br_ready_o;
  logic [1:0]       br_kind_i;
  logic [2:0]       br_op_i;
  logic [XLEN-1:0]  br_pc_i;
  logic [XLEN-1:0]  br_rs1_i;
  logic [XLEN-1:0]  br_rs2_i;
  logic [XLEN-1:0]  br_imm_i;
  logic             br_pred_taken_i;
  logic             done_valid_o;
  logic             done_taken_o;
  logic             illegal_o;
  logic             misalign_o;
  logic             redir_valid_o;
  logic             redir_ready_i;
  logic [XLEN-1:0]  redir_pc_o;
  logic             flush_o;
  logic [CNT_W-1:0] cnt_branches_o;
  logic [CNT_W-1:0] cnt_mispred_o;
  modport master (
    output br_valid_i, br_kind_i, br_op_i, br_pc_i, br_rs1_i, br_rs2_i, br_imm_i,
           br_pred_taken_i, redir_ready_i,
    input  br_ready_o, done_valid_o, done_taken_o, illegal_o, misalign_o,
           redir_valid_o, redir_pc_o, flush_o, cnt_branches_o, cnt_mispred_o
  );
  modport slave (
    input  br_valid_i, br_kind_i, br_op_i, br_pc_i, br_rs1_i, br_rs2_i, br_imm_i,
           br_pred_taken_i, redir_ready_i,
    output br_ready_o, done_valid_o, done_taken_o, illegal_o, misalign_o,
           redir_valid_o, redir_pc_o, flush_o, cnt_branches_o, cnt_mispred_o
  );
endinterface

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational func3 condition evaluation
module branch_cond_eval import branch_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  output logic            taken,
  output logic            illegal
);
  logic eq, lt, ltu;
  assign eq  = rs1 == rs2;
  assign lt  = $signed(rs1) < $signed(rs2);
  assign ltu = rs1 < rs2;
  assign taken = func3 == F3_BEQ  ? eq   :
                 func3 == F3_BNE  ? !eq  :
                 func3 == F3_BLT  ? lt   :
                 func3 == F3_BGE  ? !lt  :
                 func3 == F3_BLTU ? ltu  :
                 func3 == F3_BGEU ? !ltu : 1'b0;
  assign illegal = func3[2:1] == 2'b01;
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branches/jumps, redirects fetch on mispredict, keeps statistics
module branch_ctrl import branch_pkg::*; #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  branch_ctrl_if.slave bus
);
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  state_e           state;
  br_kind_e         kind;
  logic [2:0]       op;
  logic [XLEN-1:0]  pc, rs1, rs2, imm, redir_pc, target;
  logic             pred, cond_taken, cond_illegal, is_br, illegal, taken, misalign, mispred, eval;
  logic [FW-1:0]    fcnt;
  logic [CNT_W-1:0] cnt_br, cnt_mp;
  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .rs1(rs1), .rs2(rs2), .func3(op), .taken(cond_taken), .illegal(cond_illegal)
  );
  assign eval     = state == S_EVAL;
  assign is_br    = kind == K_BR;
  assign illegal  = kind == K_RSV || cond_illegal;
  assign taken    = is_br ? cond_taken : 1'b1;
  assign target   = kind == K_JALR ? (rs1 + imm) & ~XLEN'(1) : pc + imm;
  assign misalign = taken && target[1];
  assign mispred  = kind == K_JALR || (is_br ? taken != pred : !pred);
  assign bus.br_ready_o     = state == S_IDLE;
  assign bus.done_valid_o   = eval && !illegal;
  assign bus.done_taken_o   = eval && !illegal && taken;
  assign bus.illegal_o      = eval && illegal;
  assign bus.misalign_o     = eval && !illegal && misalign;
  assign bus.redir_valid_o  = state == S_REDIRECT;
  assign bus.redir_pc_o     = redir_pc;
  assign bus.flush_o        = state == S_REDIRECT || state == S_FLUSH;
  assign bus.cnt_branches_o = cnt_br;
  assign bus.cnt_mispred_o  = cnt_mp;
  // FSM: capture op, resolve in EVAL, hold redirect until fetch accepts, then flush window
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      kind     <= K_BR;
      op       <= '0;
      pc       <= '0;
      rs1      <= '0;
      rs2      <= '0;
      imm      <= '0;
      pred     <= 1'b0;
      redir_pc <= '0;
      fcnt     <= '0;
      cnt_br   <= '0;
      cnt_mp   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.br_valid_i) begin
          kind  <= br_kind_e'(bus.br_kind_i);
          op    <= bus.br_op_i;
          pc    <= bus.br_pc_i;
          rs1   <= bus.br_rs1_i;
          rs2   <= bus.br_rs2_i;
          imm   <= bus.br_imm_i;
          pred  <= bus.br_pred_taken_i;
          state <= S_EVAL;
        end
        S_EVAL: begin
          if (!illegal) cnt_br <= cnt_br + CNT_W'(!(&cnt_br));
          if (!illegal && !misalign && mispred) begin
            cnt_mp   <= cnt_mp + CNT_W'(!(&cnt_mp));
            redir_pc <= taken ? target : pc + XLEN'(4);
            state    <= S_REDIRECT;
          end else state <= S_IDLE;
        end
        S_REDIRECT: if (bus.redir_ready_i) begin
          fcnt  <= FW'(FLUSH_CYCLES);
          state <= FLUSH_CYCLES == 0 ? S_IDLE : S_FLUSH;
        end
        S_FLUSH: begin
          fcnt <= fcnt - FW'(1);
          if (fcnt == FW'(1)) state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed vectors with hand-computed expectations for branch_ctrl
module tb_branch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [1:0] exp_br = '0;
  logic [1:0] exp_mp = '0;
  always #5 clk = ~clk;
  branch_ctrl_if #(.XLEN(32), .CNT_W(2)) bus ();
  branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [1:0] k, input logic [2:0] f, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic pred, input logic e_ill, input logic e_tk, input logic e_mis,
                        input logic e_redir, input logic [31:0] e_pc);
    int fl;
    for (int i = 0; i < 20 && !bus.br_ready_o; i++) tick();
    check("ready_before_op", bus.br_ready_o, 1);
    bus.br_valid_i = 1; bus.br_kind_i = k; bus.br_op_i = f; bus.br_pc_i = pc;
    bus.br_rs1_i = a; bus.br_rs2_i = b; bus.br_imm_i = imm; bus.br_pred_taken_i = pred;
    tick();
    bus.br_valid_i = 0;
    check("eval_ready", bus.br_ready_o, 0);
    check("done_valid", bus.done_valid_o, !e_ill);
    check("done_taken", bus.done_taken_o, !e_ill && e_tk);
    check("illegal", bus.illegal_o, e_ill);
    check("misalign", bus.misalign_o, e_mis);
    if (!e_ill) exp_br = exp_br + 2'(exp_br != 2'b11);
    if (e_redir) exp_mp = exp_mp + 2'(exp_mp != 2'b11);
    tick();
    check("cnt_branches", bus.cnt_branches_o, exp_br);
    check("cnt_mispred", bus.cnt_mispred_o, exp_mp);
    check("redir_valid", bus.redir_valid_o, e_redir);
    check("post_done_valid", bus.done_valid_o, 0);
    if (e_redir) begin
      check("redir_pc", bus.redir_pc_o, e_pc);
      if (bus.redir_ready_i) begin
        fl = 0;
        for (int i = 0; i < 10 && !bus.br_ready_o; i++) begin
          fl += int'(bus.flush_o);
          tick();
        end
        check("flush_len", fl, 3);
        check("ready_after_flush", bus.br_ready_o, 1);
      end
    end else check("no_flush", bus.flush_o, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.br_valid_i = 0; bus.br_kind_i = 0; bus.br_op_i = 0; bus.br_pc_i = 0;
    bus.br_rs1_i = 0; bus.br_rs2_i = 0; bus.br_imm_i = 0; bus.br_pred_taken_i = 0;
    bus.redir_ready_i = 1;
    #12;
    check("rst_ready", bus.br_ready_o, 1);
    check("rst_redir_valid", bus.redir_valid_o, 0);
    check("rst_flush", bus.flush_o, 0);
    check("rst_cnt_br", bus.cnt_branches_o, 0);
    check("rst_redir_pc", bus.redir_pc_o, 0);
    #10 rst_n = 1;
    tick();
    run_op(2'd0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 0, 0, 1, 0, 1, 32'h120);
    run_op(2'd0, 3'b101, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 0, 0, 0, 0, 32'h0);
    run_op(2'd0, 3'b111, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 0, 1, 0, 1, 32'h240);
    run_op(2'd2, 3'b000, 32'h000, 32'h203, 32'd0, 32'h0, 1, 0, 1, 1, 0, 32'h0);
    run_op(2'd2, 3'b000, 32'h000, 32'h201, 32'd0, 32'h3, 1, 0, 1, 0, 1, 32'h204);
    run_op(2'd1, 3'b000, 32'h300, 32'd0, 32'd0, 32'hFFFFFFF0, 1, 0, 1, 0, 0, 32'h0);
    run_op(2'd0, 3'b100, 32'h400, 32'hFFFFFFFF, 32'd1, 32'h8, 1, 0, 1, 0, 0, 32'h0);
    run_op(2'd0, 3'b110, 32'h500, 32'hFFFFFFFF, 32'd1, 32'h8, 1, 0, 0, 0, 1, 32'h504);
    run_op(2'd0, 3'b010, 32'h600, 32'd1, 32'd1, 32'h8, 0, 1, 0, 0, 0, 32'h0);
    run_op(2'd3, 3'b000, 32'h600, 32'd1, 32'd1, 32'h8, 1, 1, 0, 0, 0, 32'h0);
    bus.redir_ready_i = 0;
    run_op(2'd0, 3'b001, 32'h600, 32'd1, 32'd2, 32'h10, 0, 0, 1, 0, 1, 32'h610);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_redir_valid", bus.redir_valid_o, 1);
      check("stall_redir_pc", bus.redir_pc_o, 32'h610);
      check("stall_ready", bus.br_ready_o, 0);
    end
    bus.redir_ready_i = 1;
    tick();
    check("rel_flush1", bus.flush_o, 1);
    check("rel_redir_drop", bus.redir_valid_o, 0);
    tick();
    check("rel_flush2", bus.flush_o, 1);
    tick();
    check("rel_idle_flush", bus.flush_o, 0);
    check("rel_idle_ready", bus.br_ready_o, 1);
    bus.redir_ready_i = 0;
    run_op(2'd0, 3'b000, 32'h700, 32'd7, 32'd7, 32'h4, 0, 0, 1, 0, 1, 32'h704);
    rst_n = 0;
    #1;
    check("mid_rst_ready", bus.br_ready_o, 1);
    check("mid_rst_redir_valid", bus.redir_valid_o, 0);
    check("mid_rst_flush", bus.flush_o, 0);
    check("mid_rst_redir_pc", bus.redir_pc_o, 0);
    check("mid_rst_cnt_br", bus.cnt_branches_o, 0);
    check("mid_rst_cnt_mp", bus.cnt_mispred_o, 0);
    check("mid_rst_done", bus.done_valid_o, 0);
    #2 rst_n = 1;
    exp_br = 0;
    exp_mp = 0;
    bus.redir_ready_i = 1;
    tick();
    for (int i = 0; i < 5; i++)
      run_op(2'd0, 3'b000, 32'h800, 32'd1, 32'd2, 32'h10, 0, 0, 0, 0, 0, 32'h0);
    check("sat_cnt_branches", bus.cnt_branches_o, 3);
    check("sat_cnt_mispred", bus.cnt_mispred_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequencing controller for control-transfer resolution in the execute stage. Accepts one branch/jump per valid/ready handshake from decode and evaluates its condition and target. It compares the outcome against decode's static prediction and, on mispredict, drives a held redirect handshake to fetch plus a pipeline flush window. It also keeps saturating branch/mispredict counters.

## Interface
- XLEN, 32: operand/PC width.
- FLUSH_CYCLES, 2: extra flush_o cycles after redirect handshake (0 allowed).
- CNT_W, 16: statistics counter width.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- br_valid_i  in  1  decode presents an op.
- br_ready_o  out  1  controller accepts (high only in IDLE).
- br_kind_i  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved (illegal).
- br_op_i  in  3  func3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- br_pc_i, br_rs1_i, br_rs2_i, br_imm_i  in  XLEN  op PC, operands, sign-extended immediate.
- br_pred_taken_i  in  1  decode predicted taken (to pc+imm).
- done_valid_o  out  1  one-cycle resolution pulse.
- done_taken_o  out  1  resolved direction, valid with done_valid_o.
- illegal_o  out  1  one-cycle pulse: func3 010/011 or kind 11.
- misalign_o  out  1  one-cycle pulse: taken target with bit 1 set.
- redir_valid_o  out  1  redirect request to fetch, held until accepted.
- redir_ready_i  in  1  fetch accepts redirect.
- redir_pc_o  out  XLEN  redirect PC, stable while redir_valid_o.
- flush_o  out  1  squash younger IF/ID instructions.
- cnt_branches_o, cnt_mispred_o  out  CNT_W  saturating statistics.

## Operation
- States: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE: br_ready_o=1; on br_valid_i register all inputs, go EVAL.
- EVAL (one cycle, outputs combinational from registered op):
  - eq = rs1==rs2; lt = signed rs1<rs2; ltu = unsigned rs1<rs2.
  - Taken: BEQ eq; BNE !eq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu; JAL/JALR always.
  - Target: branch/JAL pc+imm; JALR (rs1+imm) with bit 0 cleared. Adds modulo 2^XLEN.
  - Illegal: illegal_o=1, done_valid_o=0, no counter change, no redirect, go IDLE.
  - Taken and target[1]=1: misalign_o=1, done_valid_o=1, no redirect, cnt_branches+1, go IDLE.
  - Otherwise done_valid_o=1, cnt_branches+1.
  - Mispredict when: JALR (always); taken != pred_taken for branch; !pred_taken for JAL.
  - On mispredict: cnt_mispred+1, latch redir_pc (target if taken, else pc+4), go REDIRECT. Else go IDLE.
- REDIRECT: redir_valid_o=1, flush_o=1. On redir_ready_i go FLUSH with count FLUSH_CYCLES, or go IDLE if FLUSH_CYCLES=0.
- FLUSH: flush_o=1, count down each cycle; go IDLE after FLUSH_CYCLES cycles.
- Counters saturate at all-ones and never wrap.
- Reset values: state IDLE. Every output 0 except br_ready_o=1. Counters 0, redir_pc_o 0.

## Timing
- Accept at edge T (IDLE and valid). EVAL in cycle T+1. REDIRECT from T+2.
- Redirect handshake completes at the first edge with redir_valid_o && redir_ready_i. If ready is already high in T+2, IDLE is reached at T+3+FLUSH_CYCLES.
- Throughput without mispredict: one op per 2 cycles.
- br_ready_o=0 in EVAL/REDIRECT/FLUSH. Decode must hold its op; there is no skid buffer.
- redir_pc_o must not change while redir_valid_o is high and unacknowledged.
- Counter updates become visible the cycle after EVAL.
- Reset asserted mid-operation: everything returns to reset values immediately. A pending redirect is dropped, with no handshake completion.

## Structure
- Package branch_pkg holds: func3 constants, br_kind encodings, FSM state encoding.
- Sub-module branch_cond_eval is a combinational block that takes rs1, rs2 and func3 and produces taken and illegal. The controller owns the FSM, target arithmetic, counters and handshakes.

## Test plan
- BEQ rs1=5, rs2=5, pc=0x100, imm=0x20, pred=0 -> done_taken=1, redir_pc=0x120 at T+2, flush_o high for 1+FLUSH_CYCLES cycles after handshake, cnt_mispred=1.
- BGE rs1=0xFFFFFFFF, rs2=1, pred=0 -> not taken, no redirect. BGEU with the same operands, pred=0 -> taken, redirect issued.
- JALR rs1=0x203, imm=0 -> target 0x202, misalign_o pulse, no redirect. JALR rs1=0x201, imm=3 -> redir_pc=0x204.
- Redirect stall: hold redir_ready_i=0 for 5 cycles -> redir_valid_o and redir_pc_o stay stable and br_ready_o stays 0. Release ready -> FLUSH then IDLE.
- func3=010 with br_valid -> illegal_o pulse, no done_valid_o, counters unchanged. Counter saturation: with CNT_W=2, 5 correctly predicted branches -> cnt_branches_o=3.
- Assert rst_i low during REDIRECT -> all outputs at reset values in the same cycle. After release, a new op is accepted normally.
